// File: rtl/dma_mc_pkg.sv
// Shared types for the multi-channel DMA engine: reject codes, FSM states and the
// descriptor layout at the default widths.
package dma_mc_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 16;

  typedef enum logic [3:0] {
    OK        = 4'h0,
    ZERO_LEN  = 4'h1,
    BUSY      = 4'h2,
    ADDR_WRAP = 4'h3
  } dma_status_e;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    UPD
  } dma_state_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] src;
    logic [DEF_ADDR_W-1:0] dst;
    logic [DEF_LEN_W-1:0]  remaining;
    logic                  burst;
  } dma_desc_t;

endpackage

// File: rtl/dma_mc_ctrl_if.sv
// Descriptor, memory-port and status signals of the DMA engine; master is the engine side.
interface dma_mc_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16,
  parameter int NUM_CH = 8
);
  localparam int CH_W = $clog2(NUM_CH);

  logic              start;
  logic [CH_W-1:0]   channel;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  length;
  logic              burst;
  logic [NUM_CH-1:0] ch_busy;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic [DATA_W-1:0] rd_data;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;
  logic              done;
  logic [CH_W-1:0]   done_ch;
  logic              err;
  logic [CH_W-1:0]   err_ch;
  logic [3:0]        status;

  modport master (
    input  start, channel, src_addr, dst_addr, length, burst, rd_gnt, rd_data, wr_gnt,
    output ch_busy, rd_req, rd_addr, wr_req, wr_addr, wr_data, done, done_ch, err, err_ch, status
  );

  modport slave (
    output start, channel, src_addr, dst_addr, length, burst, rd_gnt, rd_data, wr_gnt,
    input  ch_busy, rd_req, rd_addr, wr_req, wr_addr, wr_data, done, done_ch, err, err_ch, status
  );
endinterface

// File: rtl/dma_rr_arb.sv
// Combinational round-robin pick: first requesting channel after i_ptr, wrapping.
module dma_rr_arb #(
  parameter  int NUM_CH = 8,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [CH_W-1:0]   i_ptr,
  output logic [CH_W-1:0]   o_gnt,
  output logic              o_valid
);

  always_comb begin
    o_gnt   = '0;
    o_valid = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!o_valid && i_req[CH_W'((int'(i_ptr) + i) % NUM_CH)]) begin
        o_valid = 1'b1;
        o_gnt   = CH_W'((int'(i_ptr) + i) % NUM_CH);
      end
    end
  end

endmodule

// File: rtl/dma_mc_ctrl.sv
// Multi-channel DMA: per-channel descriptor queue, chunked round-robin service,
// word-by-word copy through a read port and a write port.
module dma_mc_ctrl import dma_mc_pkg::*; #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 16,
  parameter int NUM_CH    = 8,
  parameter int MAX_BURST = 4
) (
  input logic          clk,
  input logic          rst_n,
  dma_mc_ctrl_if.master bus
);

  localparam int CH_W   = $clog2(NUM_CH);
  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam int IDX_W  = $clog2(MAX_BURST);
  localparam int EXT_W  = ADDR_W + LEN_W + 2;
  localparam int WORD_B = DATA_W / 8;

  dma_state_e        r_state, w_next;
  logic [ADDR_W-1:0] r_src [NUM_CH];
  logic [ADDR_W-1:0] r_dst [NUM_CH];
  logic [LEN_W-1:0]  r_rem [NUM_CH];
  logic [NUM_CH-1:0] r_burst, r_pending;
  logic [CH_W-1:0]   r_ptr, r_cur;
  logic [ADDR_W-1:0] r_wsrc, r_wdst;
  logic [LEN_W-1:0]  r_wrem;
  logic [BEAT_W-1:0] r_chunk, r_beat;
  logic [DATA_W-1:0] r_buf [MAX_BURST];
  logic              r_done, r_err;
  logic [CH_W-1:0]   r_done_ch, r_err_ch;
  dma_status_e       r_status, w_code;

  logic [CH_W-1:0]   w_gnt;
  logic              w_gnt_valid, w_rd_last, w_wr_last, w_reject, w_accept;
  logic [BEAT_W-1:0] w_chunk;
  logic [LEN_W-1:0]  w_sel_rem, w_new_rem;
  logic [EXT_W-1:0]  w_src_end, w_dst_end, w_limit;

  dma_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
    .i_req  (r_pending),
    .i_ptr  (r_ptr),
    .o_gnt  (w_gnt),
    .o_valid(w_gnt_valid)
  );

  assign w_sel_rem = r_rem[w_gnt];
  assign w_chunk   = !r_burst[w_gnt] ? BEAT_W'(1) :
                     (w_sel_rem > LEN_W'(MAX_BURST)) ? BEAT_W'(MAX_BURST) : BEAT_W'(w_sel_rem);
  assign w_rd_last = bus.rd_gnt && (r_beat == r_chunk - BEAT_W'(1));
  assign w_wr_last = bus.wr_gnt && (r_beat == r_chunk - BEAT_W'(1));
  assign w_new_rem = r_wrem - LEN_W'(r_chunk);

  // Transfer end is computed wide enough that a descriptor ending exactly at 2**ADDR_W is legal.
  assign w_src_end = EXT_W'(bus.src_addr) + EXT_W'(bus.length) * EXT_W'(WORD_B);
  assign w_dst_end = EXT_W'(bus.dst_addr) + EXT_W'(bus.length) * EXT_W'(WORD_B);
  assign w_limit   = EXT_W'(1) << ADDR_W;

  always_comb begin
    w_code = OK;
    if (r_pending[bus.channel])                                w_code = BUSY;
    else if (bus.length == '0)                                 w_code = ZERO_LEN;
    else if ((w_src_end > w_limit) || (w_dst_end > w_limit))   w_code = ADDR_WRAP;
  end

  assign w_reject = bus.start && (w_code != OK);
  assign w_accept = bus.start && (w_code == OK);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_gnt_valid) w_next = RD;
      RD:      if (w_rd_last)   w_next = WR;
      WR:      if (w_wr_last)   w_next = UPD;
      UPD:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.rd_req  = (r_state == RD);
    bus.rd_addr = (r_state == RD) ? r_wsrc : '0;
    bus.wr_req  = (r_state == WR);
    bus.wr_addr = (r_state == WR) ? r_wdst : '0;
    bus.wr_data = (r_state == WR) ? r_buf[r_beat[IDX_W-1:0]] : '0;
    bus.ch_busy = r_pending;
    bus.done    = r_done;
    bus.done_ch = r_done_ch;
    bus.err     = r_err;
    bus.err_ch  = r_err_ch;
    bus.status  = r_status;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_src[i] <= '0;
        r_dst[i] <= '0;
        r_rem[i] <= '0;
      end
      r_burst   <= '0;
      r_pending <= '0;
      r_ptr     <= CH_W'(NUM_CH - 1);
      r_cur     <= '0;
      r_wsrc    <= '0;
      r_wdst    <= '0;
      r_wrem    <= '0;
      r_chunk   <= '0;
      r_beat    <= '0;
      r_done    <= 1'b0;
      r_done_ch <= '0;
      r_err     <= 1'b0;
      r_err_ch  <= '0;
      r_status  <= OK;
    end else begin
      r_done    <= 1'b0;
      r_done_ch <= '0;
      r_err     <= w_reject;
      r_err_ch  <= w_reject ? bus.channel : '0;
      r_status  <= w_reject ? w_code : OK;
      if (w_accept) begin
        r_src[bus.channel]     <= bus.src_addr;
        r_dst[bus.channel]     <= bus.dst_addr;
        r_rem[bus.channel]     <= bus.length;
        r_burst[bus.channel]   <= bus.burst;
        r_pending[bus.channel] <= 1'b1;
      end
      // A start can only target a non-pending channel, so it never collides with the UPD write-back.
      case (r_state)
        IDLE: if (w_gnt_valid) begin
          r_ptr   <= w_gnt;
          r_cur   <= w_gnt;
          r_wsrc  <= r_src[w_gnt];
          r_wdst  <= r_dst[w_gnt];
          r_wrem  <= w_sel_rem;
          r_chunk <= w_chunk;
          r_beat  <= '0;
        end
        RD: if (bus.rd_gnt) begin
          r_wsrc <= r_wsrc + ADDR_W'(WORD_B);
          r_beat <= w_rd_last ? '0 : r_beat + BEAT_W'(1);
        end
        WR: if (bus.wr_gnt) begin
          r_wdst <= r_wdst + ADDR_W'(WORD_B);
          r_beat <= w_wr_last ? '0 : r_beat + BEAT_W'(1);
        end
        UPD: begin
          r_src[r_cur] <= r_wsrc;
          r_dst[r_cur] <= r_wdst;
          r_rem[r_cur] <= w_new_rem;
          if (w_new_rem == '0) begin
            r_pending[r_cur] <= 1'b0;
            r_done           <= 1'b1;
            r_done_ch        <= r_cur;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == RD && bus.rd_gnt) r_buf[r_beat[IDX_W-1:0]] <= bus.rd_data;
  end

endmodule

// File: tb/tb_dma_mc_ctrl.sv
// Scoreboard bench for dma_mc_ctrl: expected writes and completions are queued when a
// descriptor is started and matched by a negedge monitor as the engine produces them.
module tb_dma_mc_ctrl;
  import dma_mc_pkg::*;

  localparam int ADDR_W = 32, DATA_W = 32, LEN_W = 16, NUM_CH = 8, MAX_BURST = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  wr_exp_t    wr_q[$];
  logic [2:0] done_q[$];

  always #5 clk = ~clk;

  dma_mc_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .NUM_CH(NUM_CH)) bus ();

  dma_mc_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .NUM_CH(NUM_CH), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign bus.rd_data = mem_word(bus.rd_addr);

  always @(negedge clk) begin : monitor
    wr_exp_t    e;
    logic [2:0] dc;
    if (rst_n === 1'b1) begin
      if (bus.rd_req && bus.wr_req) begin
        n_checks++;
        $display("[TB] FAIL req_overlap rd_req=%b wr_req=%b required not both high", bus.rd_req, bus.wr_req);
      end
      if (bus.wr_req && bus.wr_gnt) begin
        n_checks++;
        if (wr_q.size() == 0) begin
          $display("[TB] FAIL sb_write unexpected addr=%h data=%h required none", bus.wr_addr, bus.wr_data);
        end else begin
          e = wr_q.pop_front();
          if (bus.wr_addr !== e.addr || bus.wr_data !== e.data)
            $display("[TB] FAIL sb_write got addr=%h data=%h required addr=%h data=%h",
                     bus.wr_addr, bus.wr_data, e.addr, e.data);
          else n_pass++;
        end
      end
      if (bus.done) begin
        n_checks++;
        if (done_q.size() == 0) begin
          $display("[TB] FAIL sb_done unexpected done_ch=%0d required none", bus.done_ch);
        end else begin
          dc = done_q.pop_front();
          if (bus.done_ch !== dc) $display("[TB] FAIL sb_done got ch=%0d required ch=%0d", bus.done_ch, dc);
          else n_pass++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [2:0] ch, input logic [31:0] src, input logic [31:0] dst,
                             input logic [15:0] len, input logic bst);
    bus.start    = 1'b1;
    bus.channel  = ch;
    bus.src_addr = src;
    bus.dst_addr = dst;
    bus.length   = len;
    bus.burst    = bst;
    tick();
    bus.start    = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((wr_q.size() != 0 || done_q.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    if (wr_q.size() != 0 || done_q.size() != 0)
      $display("[TB] FAIL drain_timeout pending writes=%0d dones=%0d required 0/0", wr_q.size(), done_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({bus.ch_busy, bus.rd_req, bus.rd_addr, bus.wr_req, bus.wr_addr, bus.wr_data,
         bus.done, bus.done_ch, bus.err, bus.err_ch, bus.status} !== '0)
      $display("[TB] FAIL reset_outputs busy=%h rd_req=%b wr_req=%b done=%b err=%b status=%h required all 0",
               bus.ch_busy, bus.rd_req, bus.wr_req, bus.done, bus.err, bus.status);
    else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_word();
    wr_q.push_back('{32'h200, mem_word(32'h100)});
    done_q.push_back(3'd0);
    drive_start(3'd0, 32'h100, 32'h200, 16'd1, 1'b0);
    n_checks++;
    if (bus.ch_busy !== 8'h01 || bus.rd_req !== 1'b0)
      $display("[TB] FAIL single_c1 busy=%h rd_req=%b required busy=01 rd_req=0", bus.ch_busy, bus.rd_req);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.rd_req !== 1'b1 || bus.rd_addr !== 32'h100)
      $display("[TB] FAIL single_c2 rd_req=%b rd_addr=%h required 1/00000100", bus.rd_req, bus.rd_addr);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.wr_req !== 1'b1 || bus.wr_addr !== 32'h200 || bus.wr_data !== mem_word(32'h100))
      $display("[TB] FAIL single_c3 wr_req=%b wr_addr=%h wr_data=%h required 1/00000200/%h",
               bus.wr_req, bus.wr_addr, bus.wr_data, mem_word(32'h100));
    else n_pass++;
    tick();
    n_checks++;
    if (bus.done !== 1'b0 || bus.wr_req !== 1'b0 || bus.rd_req !== 1'b0)
      $display("[TB] FAIL single_c4 done=%b wr_req=%b rd_req=%b required 0/0/0", bus.done, bus.wr_req, bus.rd_req);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.done !== 1'b1 || bus.done_ch !== 3'd0 || bus.ch_busy !== 8'h00)
      $display("[TB] FAIL single_c5 done=%b done_ch=%0d busy=%h required 1/0/00", bus.done, bus.done_ch, bus.ch_busy);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.done !== 1'b0)
      $display("[TB] FAIL single_c6 done=%b required 0", bus.done);
    else n_pass++;
    wait_drain(10);
  endtask

  task automatic test_burst_split();
    int runs[$];
    int run = 0;
    for (int i = 0; i < 6; i++)
      wr_q.push_back('{32'h2000 + 32'(4 * i), mem_word(32'h1000 + 32'(4 * i))});
    done_q.push_back(3'd3);
    drive_start(3'd3, 32'h1000, 32'h2000, 16'd6, 1'b1);
    for (int k = 0; k < 60 && done_q.size() != 0; k++) begin
      if (bus.rd_req) run++;
      else if (run != 0) begin
        runs.push_back(run);
        run = 0;
      end
      tick();
    end
    n_checks++;
    if (runs.size() != 2 || runs[0] != 4 || runs[1] != 2)
      $display("[TB] FAIL burst_chunks got %0d chunks first=%0d second=%0d required 2 chunks 4 then 2",
               runs.size(), (runs.size() > 0) ? runs[0] : -1, (runs.size() > 1) ? runs[1] : -1);
    else n_pass++;
    wait_drain(10);
    n_checks++;
    if (bus.ch_busy !== 8'h00)
      $display("[TB] FAIL burst_busy_clear busy=%h required 00", bus.ch_busy);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    wr_q.push_back('{32'h3100, mem_word(32'h3000)});
    wr_q.push_back('{32'h4100, mem_word(32'h4000)});
    wr_q.push_back('{32'h3104, mem_word(32'h3004)});
    wr_q.push_back('{32'h4104, mem_word(32'h4004)});
    done_q.push_back(3'd1);
    done_q.push_back(3'd2);
    drive_start(3'd1, 32'h3000, 32'h3100, 16'd2, 1'b0);
    drive_start(3'd2, 32'h4000, 32'h4100, 16'd2, 1'b0);
    wait_drain(100);
  endtask

  task automatic test_rejects();
    logic [2:0]  r_ch [5]  = '{3'd4, 3'd4, 3'd6, 3'd7, 3'd7};
    logic [31:0] r_src[5]  = '{32'h6000, 32'h6000, 32'h6000, 32'hFFFF_FFFC, 32'h6000};
    logic [31:0] r_dst[5]  = '{32'h6100, 32'h6100, 32'h6100, 32'h6100, 32'hFFFF_FFF8};
    logic [15:0] r_len[5]  = '{16'd1, 16'd0, 16'd0, 16'd2, 16'd3};
    logic [3:0]  r_code[5] = '{4'h2, 4'h2, 4'h1, 4'h3, 4'h3};
    bus.rd_gnt = 1'b0;
    wr_q.push_back('{32'h5100, mem_word(32'h5000)});
    done_q.push_back(3'd4);
    drive_start(3'd4, 32'h5000, 32'h5100, 16'd1, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive_start(r_ch[i], r_src[i], r_dst[i], r_len[i], 1'b0);
      n_checks++;
      if (bus.err !== 1'b1 || bus.err_ch !== r_ch[i] || bus.status !== r_code[i] || bus.ch_busy !== 8'h10)
        $display("[TB] FAIL reject_%0d err=%b err_ch=%0d status=%h busy=%h required 1/%0d/%h/10",
                 i, bus.err, bus.err_ch, bus.status, bus.ch_busy, r_ch[i], r_code[i]);
      else n_pass++;
      tick();
      n_checks++;
      if (bus.err !== 1'b0)
        $display("[TB] FAIL reject_pulse_%0d err=%b required 0", i, bus.err);
      else n_pass++;
    end
    wr_q.push_back('{32'h6200, mem_word(32'hFFFF_FFFC)});
    done_q.push_back(3'd7);
    drive_start(3'd7, 32'hFFFF_FFFC, 32'h6200, 16'd1, 1'b0);
    n_checks++;
    if (bus.err !== 1'b0 || bus.ch_busy !== 8'h90)
      $display("[TB] FAIL wrap_boundary_accept err=%b busy=%h required 0/90", bus.err, bus.ch_busy);
    else n_pass++;
    bus.rd_gnt = 1'b1;
    wait_drain(100);
  endtask

  task automatic test_wait_states();
    int k = 0;
    bus.rd_gnt = 1'b0;
    wr_q.push_back('{32'h500, mem_word(32'h400)});
    done_q.push_back(3'd0);
    drive_start(3'd0, 32'h400, 32'h500, 16'd1, 1'b0);
    while (bus.rd_req !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (bus.rd_req !== 1'b1 || bus.rd_addr !== 32'h400)
        $display("[TB] FAIL wait_rd_hold_%0d rd_req=%b rd_addr=%h required 1/00000400", c, bus.rd_req, bus.rd_addr);
      else n_pass++;
      tick();
    end
    bus.rd_gnt = 1'b1;
    wait_drain(50);
  endtask

  task automatic test_reset_mid();
    int k = 0;
    bus.wr_gnt = 1'b0;
    drive_start(3'd5, 32'h7000, 32'h7100, 16'd2, 1'b0);
    while (bus.wr_req !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    n_checks++;
    if (bus.wr_req !== 1'b1) $display("[TB] FAIL reset_mid_reach_wr wr_req=%b required 1", bus.wr_req);
    else n_pass++;
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (bus.rd_req !== 1'b0 || bus.wr_req !== 1'b0 || bus.ch_busy !== 8'h00 || bus.done !== 1'b0)
      $display("[TB] FAIL reset_mid rd_req=%b wr_req=%b busy=%h done=%b required 0/0/00/0",
               bus.rd_req, bus.wr_req, bus.ch_busy, bus.done);
    else n_pass++;
    rst_n = 1'b1;
    bus.wr_gnt = 1'b1;
    repeat (10) tick();
    n_checks++;
    if (bus.ch_busy !== 8'h00 || bus.wr_req !== 1'b0)
      $display("[TB] FAIL reset_mid_after busy=%h wr_req=%b required 00/0", bus.ch_busy, bus.wr_req);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.channel  = '0;
    bus.src_addr = '0;
    bus.dst_addr = '0;
    bus.length   = '0;
    bus.burst    = 1'b0;
    bus.rd_gnt   = 1'b1;
    bus.wr_gnt   = 1'b1;
    test_reset();
    test_single_word();
    test_burst_split();
    test_round_robin();
    test_rejects();
    test_wait_states();
    test_reset_mid();
    n_checks++;
    if (wr_q.size() != 0 || done_q.size() != 0)
      $display("[TB] FAIL final_queues writes=%0d dones=%0d required 0/0", wr_q.size(), done_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dma_mc_ctrl.md
# dma_mc_ctrl

Parametrised multi-channel DMA engine and successor to the single-descriptor DMA block. It accepts per-channel descriptors (src, dst, length, burst) on a start pulse and queues them as pending. It moves data word-by-word through a read port and a write port, arbitrating round-robin between pending channels at chunk granularity. It reports per-transfer completion and start-time errors, and sits between the testbench/register agent and the memory model in the `dma_ctrl` environment.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data word width; the address stride per word is `DATA_W/8` bytes.
- `LEN_W`, 16: length width, counted in words.
- `NUM_CH`, 8: channel count, ≥2; `CH_W = $clog2(NUM_CH)`.
- `MAX_BURST`, 4: words per chunk when burst=1, ≥2; it is also the depth of the internal buffer.
- `clk`  in  1  clock, all logic on the rising edge.
- `rst_n`  in  1  reset. Reset is synchronous and active-low: one clock, synchronous active-low reset.
- `start`  in  1  one-cycle descriptor strobe.
- `channel`  in  CH_W  target channel of `start`.
- `src_addr`, `dst_addr`  in  ADDR_W  byte addresses.
- `length`  in  LEN_W  word count.
- `burst`  in  1  1 = chunks of up to MAX_BURST words; 0 = single-word chunks.
- `ch_busy`  out  NUM_CH  per-channel pending flag.
- `rd_req`  out  1; `rd_addr`  out  ADDR_W; `rd_gnt`  in  1; `rd_data`  in  DATA_W. Read data is valid in the cycle where `rd_req && rd_gnt`.
- `wr_req`  out  1; `wr_addr`  out  ADDR_W; `wr_data`  out  DATA_W; `wr_gnt`  in  1.
- `done`  out  1  one-cycle completion pulse; `done_ch`  out  CH_W  channel that completed.
- `err`  out  1  one-cycle reject pulse; `err_ch`  out  CH_W  rejected channel; `status`  out  4  reject code.

## Operation
- **Start checks.** Each start is checked in priority order:
  - Channel already pending → BUSY (4'h2).
  - length==0 → ZERO_LEN (4'h1).
  - `addr + length*DATA_W/8 > 2**ADDR_W` for src or dst → ADDR_WRAP (4'h3). Compute at ADDR_W+LEN_W+2 bits.
  - A rejected start leaves the channel untouched and pulses `err`/`err_ch`/`status` on the next cycle.
  - Otherwise the descriptor is loaded and `ch_busy[channel]` is set on the next cycle.
- **State machine.** States are IDLE, RD, WR, UPD.
  - **IDLE:** if any channel is pending, the arbiter picks the first pending channel after the last served one (wrapping). Its registers are copied to the working copy. chunk = burst ? min(remaining, MAX_BURST) : 1. Next state is RD.
  - **RD:** `rd_req` is held high. On each `rd_gnt`, buffer[beat] ← `rd_data` and src advances by one word. After `chunk` grants, go to WR.
  - **WR:** `wr_req` is held high with `wr_data` = buffer[beat]. On each `wr_gnt`, dst advances by one word. After `chunk` grants, go to UPD.
  - **UPD:** write src, dst and remaining−chunk back to the channel. If the result is 0, clear pending and set `done`/`done_ch` for the next cycle. Next state is IDLE.
- **Handshake rules.** `rd_addr` and `wr_addr` are stable while their req is high. A req never drops without a grant except on reset. `rd_req` and `wr_req` are never high together.
- **Start during the channel's own UPD:** the channel is still pending, so the start is rejected with BUSY.
- **Start to a different channel** is accepted in any state, including in the same cycle as a `done`.
- **Arbiter pointer:** updated only in IDLE when a grant is issued. It resets to NUM_CH−1, so channel 0 wins first.

## Timing
- **Reset values:** state IDLE, all pending cleared, pointer NUM_CH−1. All outputs are 0: `ch_busy`, reqs, addresses, `wr_data`, `done`, `done_ch`, `err`, `err_ch`, `status`.
- **Reset mid-transfer:** reqs drop on the cycle after `rst_n` is sampled low. No `done` follows.
- **Minimum latency,** single word with grants at zero wait:
  - Start sampled at edge 0.
  - Pending visible from cycle 1; IDLE arbitrates in cycle 1.
  - RD in cycle 2, WR in cycle 3, UPD in cycle 4.
  - `done` is high in cycle 5.
- **Per chunk of n words with zero-wait grants:** n + n + 2 cycles (RD n, WR n, UPD 1, IDLE 1).
- **Reject path:** `err` is high exactly one cycle after the offending start.

## Structure
- **Package `dma_mc_pkg`:**
  - `dma_status_e`: OK=0, ZERO_LEN=1, BUSY=2, ADDR_WRAP=3.
  - `dma_state_e`: IDLE, RD, WR, UPD.
  - `dma_desc_t`: src, dst, remaining, burst, using the default widths.
- **Sub-module `dma_rr_arb`:** parametrised on NUM_CH. Takes the request vector and pointer and returns the grant index and a valid flag. It is purely combinational; the pointer register stays in the parent.

## Test plan
- **Single word:** ch0, src 0x100, dst 0x200, len 1, burst 0, grants tied high. Expect `rd_addr` 0x100 in cycle 2, `wr_addr` 0x200 with the read data in cycle 3, `done`=1 with `done_ch`=0 in cycle 5.
- **Burst split:** ch3, len 6, burst 1, MAX_BURST 4. Expect chunks of 4 then 2. Addresses increment by 4 bytes. Exactly one `done`, after the 6th write.
- **Round-robin interleave:** ch1 and ch2 both started with len 2, burst 0. Expect write order ch1, ch2, ch1, ch2; `done` for ch1, then `done` for ch2.
- **Rejects:**
  - len 0 → `err`, `status` 1.
  - Restart of a pending channel → `status` 2.
  - src 0xFFFF_FFFC with len 2 → `status` 3.
  - In all three cases `ch_busy` is unchanged.
- **Wait states and reset:**
  - `rd_gnt` held low for 3 cycles: `rd_addr` stays stable and the data is still correct.
  - `rst_n` asserted low during WR: reqs are 0 the next cycle, `ch_busy` is 0, and no `done` occurs.
